// File: rtl/alu_defs.sv
// Shared ALU-issue encodings: ALU op codes, main-control op classes, R-type funct codes, buffer states.
package alu_defs;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_NOR = 4'b1100;

    localparam logic [1:0] CLASS_MEM    = 2'b00;
    localparam logic [1:0] CLASS_BRANCH = 2'b01;
    localparam logic [1:0] CLASS_RTYPE  = 2'b10;
    localparam logic [1:0] CLASS_ORI    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: decoded instruction in, writeback snoop, flush, and ALU operand/op out.
interface alu_issue_stage_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_class;
    logic [5:0]       in_funct;
    logic [IDXW-1:0]  in_rs_idx;
    logic [IDXW-1:0]  in_rt_idx;
    logic [IDXW-1:0]  in_rd_idx;
    logic [WIDTH-1:0] in_rs_data;
    logic [WIDTH-1:0] in_rt_data;
    logic [15:0]      in_imm;
    logic             in_alusrc;
    logic             wb_valid;
    logic [IDXW-1:0]  wb_idx;
    logic [WIDTH-1:0] wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [3:0]       out_aluop;
    logic [IDXW-1:0]  out_rd_idx;
    logic             out_wen;
    logic             out_illegal;

    modport master (
        output flush, in_valid, in_class, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
               in_rs_data, in_rt_data, in_imm, in_alusrc, wb_valid, wb_idx, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_aluop, out_rd_idx, out_wen, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_class, in_funct, in_rs_idx, in_rt_idx, in_rd_idx,
               in_rs_data, in_rt_data, in_imm, in_alusrc, wb_valid, wb_idx, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b, out_aluop, out_rd_idx, out_wen, out_illegal
    );

endinterface

// File: rtl/alu_control.sv
// ALU control decode: (op class, funct) -> 4-bit ALU op plus an illegal-funct flag.
// Purely combinational, no latency, no backpressure.
module alu_control
    import alu_defs::*;
(
    input  logic [1:0] op_class,
    input  logic [5:0] funct,
    output logic [3:0] aluop,
    output logic       illegal
);

    always_comb begin
        aluop   = ALUOP_AND;
        illegal = 1'b0;
        case (op_class)
            CLASS_MEM:    aluop = ALUOP_ADD;
            CLASS_BRANCH: aluop = ALUOP_SUB;
            CLASS_ORI:    aluop = ALUOP_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: aluop = ALUOP_ADD;
                    FUNCT_SUB: aluop = ALUOP_SUB;
                    FUNCT_AND: aluop = ALUOP_AND;
                    FUNCT_OR:  aluop = ALUOP_OR;
                    FUNCT_SLT: aluop = ALUOP_SLT;
                    FUNCT_NOR: aluop = ALUOP_NOR;
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: ALU-op decode, writeback forwarding, B-operand select, 2-entry skid buffer.
// One-cycle latency; in_ready is registered and drops only once the skid entry is occupied.
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       aluop;
        logic [IDXW-1:0]  rd_idx;
        logic             wen;
        logic             illegal;
    } entry_t;

    buf_state_t       state;
    entry_t           main_q;
    entry_t           skid_q;
    entry_t           new_entry;
    logic             in_ready_q;
    logic [3:0]       ctrl_aluop;
    logic             ctrl_illegal;
    logic [WIDTH-1:0] rs_fwd;
    logic [WIDTH-1:0] rt_fwd;
    logic [WIDTH-1:0] imm_ext;
    logic             accept;
    logic             drain;

    alu_control u_alu_control (
        .op_class (bus.in_class),
        .funct    (bus.in_funct),
        .aluop    (ctrl_aluop),
        .illegal  (ctrl_illegal)
    );

    // Forwarding is resolved only at acceptance; buffered entries never see later writebacks.
    always_comb begin
        rs_fwd = (bus.wb_valid && (bus.wb_idx == bus.in_rs_idx) && (bus.in_rs_idx != '0))
                 ? bus.wb_data : bus.in_rs_data;
        rt_fwd = (bus.wb_valid && (bus.wb_idx == bus.in_rt_idx) && (bus.in_rt_idx != '0))
                 ? bus.wb_data : bus.in_rt_data;
        imm_ext = (bus.in_class == CLASS_ORI)
                  ? {{(WIDTH-16){1'b0}}, bus.in_imm}
                  : {{(WIDTH-16){bus.in_imm[15]}}, bus.in_imm};

        new_entry         = '0;
        new_entry.a       = rs_fwd;
        new_entry.b       = bus.in_alusrc ? imm_ext : rt_fwd;
        new_entry.aluop   = ctrl_aluop;
        new_entry.rd_idx  = bus.in_rd_idx;
        new_entry.illegal = ctrl_illegal;
        new_entry.wen     = (bus.in_rd_idx != '0) && !ctrl_illegal;
    end

    assign accept = bus.in_valid && in_ready_q && !bus.flush;
    assign drain  = (state != BUF_EMPTY) && bus.out_ready;

    // in_ready is set to (next state != TWO) alongside every state update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q <= new_entry;
                        state  <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && drain) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        skid_q     <= new_entry;
                        state      <= BUF_TWO;
                        in_ready_q <= 1'b0;
                    end else if (drain) begin
                        state <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        main_q     <= skid_q;
                        state      <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= BUF_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (state != BUF_EMPTY);
    assign bus.out_a       = main_q.a;
    assign bus.out_b       = main_q.b;
    assign bus.out_aluop   = main_q.aluop;
    assign bus.out_rd_idx  = main_q.rd_idx;
    assign bus.out_wen     = main_q.wen;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed test-plan steps plus randomized traffic against a queue model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.WIDTH(32), .IDXW(5)) bus ();

    alu_issue_stage #(.WIDTH(32), .IDXW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [5:0] legal_funct [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected entry for whatever is currently offered, straight from the decode/forward rules.
    function automatic exp_t predict();
        exp_t e;
        logic [31:0] rs, rt, imm;
        rs = (bus.wb_valid && bus.wb_idx == bus.in_rs_idx && bus.in_rs_idx != 5'd0) ? bus.wb_data : bus.in_rs_data;
        rt = (bus.wb_valid && bus.wb_idx == bus.in_rt_idx && bus.in_rt_idx != 5'd0) ? bus.wb_data : bus.in_rt_data;
        imm = (bus.in_class == 2'b11) ? {16'h0000, bus.in_imm} : {{16{bus.in_imm[15]}}, bus.in_imm};
        e.a   = rs;
        e.b   = bus.in_alusrc ? imm : rt;
        e.ill = 1'b0;
        e.op  = 4'b0000;
        case (bus.in_class)
            2'b00: e.op = 4'b0010;
            2'b01: e.op = 4'b0110;
            2'b11: e.op = 4'b0001;
            default: begin
                case (bus.in_funct)
                    6'b100000: e.op = 4'b0010;
                    6'b100010: e.op = 4'b0110;
                    6'b100100: e.op = 4'b0000;
                    6'b100101: e.op = 4'b0001;
                    6'b101010: e.op = 4'b0111;
                    6'b100111: e.op = 4'b1100;
                    default:   e.ill = 1'b1;
                endcase
            end
        endcase
        e.rd  = bus.in_rd_idx;
        e.wen = (bus.in_rd_idx != 5'd0) && !e.ill;
        return e;
    endfunction

    task automatic check_model();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_a", bus.out_a, q[0].a);
            chk("out_b", bus.out_b, q[0].b);
            chk("out_aluop", 32'(bus.out_aluop), 32'(q[0].op));
            chk("out_rd_idx", 32'(bus.out_rd_idx), 32'(q[0].rd));
            chk("out_wen", 32'(bus.out_wen), 32'(q[0].wen));
            chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
        end
    endtask

    // Advance one edge: update the FIFO model from the inputs the DUT is about to sample.
    task automatic tick();
        exp_t e;
        logic drn, acc;
        e = predict();
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            drn = (q.size() > 0) && bus.out_ready;
            acc = bus.in_valid && (q.size() < 2);
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_class   = 2'b00;
        bus.in_funct   = 6'h00;
        bus.in_rs_idx  = 5'd0;
        bus.in_rt_idx  = 5'd0;
        bus.in_rd_idx  = 5'd0;
        bus.in_rs_data = 32'h0;
        bus.in_rt_data = 32'h0;
        bus.in_imm     = 16'h0;
        bus.in_alusrc  = 1'b0;
        bus.wb_valid   = 1'b0;
        bus.wb_idx     = 5'd0;
        bus.wb_data    = 32'h0;
        bus.out_ready  = 1'b1;
    endtask

    task automatic instr(input logic [1:0] c, input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [15:0] imm, input logic src);
        bus.in_valid   = 1'b1;
        bus.in_class   = c;
        bus.in_funct   = f;
        bus.in_rs_idx  = rs;
        bus.in_rt_idx  = rt;
        bus.in_rd_idx  = rd;
        bus.in_rs_data = rsd;
        bus.in_rt_data = rtd;
        bus.in_imm     = imm;
        bus.in_alusrc  = src;
    endtask

    task automatic expect_lit(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op, input logic wen);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_a"}, bus.out_a, a);
        chk({tag, "_b"}, bus.out_b, b);
        chk({tag, "_aluop"}, 32'(bus.out_aluop), 32'(op));
        chk({tag, "_wen"}, 32'(bus.out_wen), 32'(wen));
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_out_a"}, bus.out_a, 32'd0);
        chk({tag, "_out_b"}, bus.out_b, 32'd0);
        chk({tag, "_out_aluop"}, 32'(bus.out_aluop), 32'd0);
        chk({tag, "_out_rd_idx"}, 32'(bus.out_rd_idx), 32'd0);
        chk({tag, "_out_wen"}, 32'(bus.out_wen), 32'd0);
        chk({tag, "_out_illegal"}, 32'(bus.out_illegal), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        expect_reset("rst_init");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type add with plain register operands
        instr(2'b10, 6'b100000, 5'd5, 5'd6, 5'd3, 32'd7, 32'd3, 16'h0, 1'b0);
        tick();
        expect_lit("radd", 32'd7, 32'd3, 4'b0010, 1'b1);

        // Immediate extension: zero for ori, sign for mem
        instr(2'b11, 6'h00, 5'd1, 5'd2, 5'd4, 32'h11, 32'h22, 16'h8001, 1'b1);
        tick();
        expect_lit("ori", 32'h11, 32'h0000_8001, 4'b0001, 1'b1);
        instr(2'b00, 6'h00, 5'd1, 5'd2, 5'd4, 32'h11, 32'h22, 16'h8001, 1'b1);
        tick();
        expect_lit("mem", 32'h11, 32'hFFFF_8001, 4'b0010, 1'b1);

        // Forwarding hit on rs, then index 0 never forwarded
        instr(2'b10, 6'b100000, 5'd5, 5'd6, 5'd7, 32'd1, 32'd2, 16'h0, 1'b0);
        bus.wb_valid = 1'b1; bus.wb_idx = 5'd5; bus.wb_data = 32'd99;
        tick();
        expect_lit("fwd_rs", 32'd99, 32'd2, 4'b0010, 1'b1);
        instr(2'b10, 6'b100000, 5'd0, 5'd6, 5'd7, 32'd55, 32'd2, 16'h0, 1'b0);
        bus.wb_idx = 5'd0;
        tick();
        expect_lit("fwd_zero", 32'd55, 32'd2, 4'b0010, 1'b1);
        bus.wb_valid = 1'b0;

        // Illegal funct, then legal op targeting r0
        instr(2'b10, 6'b000000, 5'd1, 5'd2, 5'd3, 32'd10, 32'd20, 16'h0, 1'b0);
        tick();
        expect_lit("illegal", 32'd10, 32'd20, 4'b0000, 1'b0);
        chk("illegal_flag", 32'(bus.out_illegal), 32'd1);
        instr(2'b10, 6'b100010, 5'd1, 5'd2, 5'd0, 32'd10, 32'd20, 16'h0, 1'b0);
        tick();
        expect_lit("rd_zero", 32'd10, 32'd20, 4'b0110, 1'b0);

        // Backpressure: two accepted, third refused, then ordered drain
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        instr(2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd100, 32'd1, 16'h0, 1'b0);
        tick();
        instr(2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd200, 32'd1, 16'h0, 1'b0);
        tick();
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        instr(2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd300, 32'd1, 16'h0, 1'b0);
        tick();
        chk("bp_stall_a", bus.out_a, 32'd100);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_second_a", bus.out_a, 32'd200);
        chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
        tick();
        chk("bp_drained", 32'(bus.out_valid), 32'd0);

        // Flush with the buffer full and an instruction on offer
        bus.out_ready = 1'b0;
        instr(2'b01, 6'h00, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 16'h0, 1'b0);
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("flush_not_taken", 32'(bus.out_valid), 32'd0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.in_class   = 2'($urandom_range(0, 3));
            bus.in_funct   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal_funct[$urandom_range(0, 5)];
            bus.in_rs_idx  = 5'($urandom_range(0, 7));
            bus.in_rt_idx  = 5'($urandom_range(0, 7));
            bus.in_rd_idx  = 5'($urandom_range(0, 7));
            bus.in_rs_data = $urandom;
            bus.in_rt_data = $urandom;
            bus.in_imm     = 16'($urandom);
            bus.in_alusrc  = 1'($urandom_range(0, 1));
            bus.wb_valid   = 1'($urandom_range(0, 1));
            bus.wb_idx     = 5'($urandom_range(0, 7));
            bus.wb_data    = $urandom;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            tick();
        end

        // Asynchronous reset in the middle of a full buffer
        idle();
        bus.out_ready = 1'b0;
        instr(2'b10, 6'b100101, 5'd3, 5'd4, 5'd5, 32'hAAAA_0000, 32'h0000_5555, 16'h0, 1'b0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        expect_reset("rst_mid");
        q.delete();
        tick();
        rst = 1'b0;
        idle();
        tick();
        chk("post_reset_empty", 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue stage directly upstream of the 32-bit ALU. It accepts one decoded instruction per cycle over a valid/ready handshake and generates the 4-bit ALU operation code from the main-control op class and funct field. It selects and extends the B operand, forwards a pending writeback onto A/B, and presents registered A, B and ALU-op outputs to the ALU through a 2-entry skid buffer, giving full throughput with a registered `in_ready`.

## Interface
- `WIDTH`, 32, datapath width of A/B/results
- `IDXW`, 5, register index width
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `flush` input 1: synchronous; discards all buffered entries
- `in_valid` input 1: upstream offers an instruction
- `in_ready` output 1: stage can accept (registered)
- `in_class` input 2: main-control op class: 00 mem (add), 01 branch (sub), 10 R-type (use funct), 11 ori (or)
- `in_funct` input 6: R-type funct
- `in_rs_idx`, `in_rt_idx`, `in_rd_idx` input IDXW each: source and destination indices
- `in_rs_data`, `in_rt_data` input WIDTH each: register-file read data
- `in_imm` input 16: immediate
- `in_alusrc` input 1: 1 = B from extended immediate, 0 = B from rt
- `wb_valid` input 1, `wb_idx` input IDXW, `wb_data` input WIDTH: writeback being committed this cycle
- `out_valid` output 1; `out_ready` input 1: downstream handshake
- `out_a`, `out_b` output WIDTH: ALU operands
- `out_aluop` output 4: ALU operation code
- `out_rd_idx` output IDXW; `out_wen` output 1: destination write enable
- `out_illegal` output 1: entry carries an undefined funct

## Operation
- Transfer occurs on `in_valid && in_ready` or `out_valid && out_ready`.
- ALU-op decode:
  - class 00 → 0010
  - class 01 → 0110
  - class 11 → 0001
  - class 10 by funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111, 100111→1100
  - any other funct → aluop 0000, `out_illegal`=1, `out_wen`=0
- Immediate extension: zero-extend for class 11; sign-extend otherwise.
- Forwarding at acceptance only:
  - If `wb_valid` and `wb_idx`==rs_idx and rs_idx≠0, A = `wb_data`; otherwise A = rs_data.
  - The same rule applies to rt before the alusrc mux.
  - Index 0 is never forwarded.
- `out_wen` = 0 when rd_idx == 0 or the entry is illegal; 1 otherwise.
- Skid buffer states: EMPTY, ONE (main register full), TWO (main and skid full).
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → TWO; input captured into skid.
  - ONE + accept + drain → ONE; main reloads from input.
  - ONE + drain, no accept → EMPTY.
  - TWO + drain → ONE; skid moves to main.
  - TWO never accepts.
- `in_ready` = (next state ≠ TWO), registered.
- Order is strictly FIFO; no entry is dropped or duplicated.
- `flush`:
  - State → EMPTY next cycle.
  - An input offered in the flush cycle is not accepted.
  - `in_ready`=1 in the following cycle.
  - `flush` has priority over accept and drain.

## Timing
- Reset values: state EMPTY, `in_ready`=1, `out_valid`=0, `out_a`=`out_b`=0, `out_aluop`=0, `out_rd_idx`=0, `out_wen`=0, `out_illegal`=0.
- Reset is effective immediately, mid-transfer included; buffered entries are lost.
- Latency: input accepted at edge N → `out_valid`=1 after edge N (one cycle).
- Throughput: one instruction per cycle while `out_ready`=1.
- Stall: `out_*` hold stable while `out_valid && !out_ready`.
- `in_ready` deasserts the cycle after the skid fills.
- Forwarding uses `wb_*` sampled on the same edge as acceptance.
- A writeback in any later cycle does not update entries already buffered.

## Structure
- Shared package/include `alu_defs`:
  - ALU-op constants (AND, OR, ADD, SUB, SLT, NOR)
  - class encodings
  - funct constants
  - the buffer-state enum
- One combinational sub-module, `alu_control`: (class, funct) → (aluop, illegal).
- Forwarding, extension and the skid buffer remain in this module.

## Test plan
- R-type add, funct 100000, rs=5 (7), rt=6 (3), out_ready=1 → after 1 cycle: out_a=7, out_b=3, out_aluop=0010, out_wen=1.
- ori, class 11, imm=16'h8001, alusrc=1 → out_b=32'h00008001, aluop=0001. Same imm with class 00 → out_b=32'hFFFF8001, aluop=0010.
- wb_valid, wb_idx=5, wb_data=99 in the same cycle as accepting rs=5 → out_a=99. With rs_idx=0 and wb_idx=0 → out_a = in_rs_data.
- out_ready held 0 while offering 3 back-to-back instructions → first two accepted, in_ready=0 from the third cycle. Release out_ready → outputs appear in order, one per cycle.
- funct 000000 in class 10 → out_illegal=1, out_aluop=0000, out_wen=0. rd_idx=0 on a legal op → out_wen=0.
- Buffer in TWO, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, offered instruction not accepted. Assert rst mid-stream → all outputs read their reset values immediately.
